uram_stream_reader: RTL and testbench
=====================================

// Module: uram_stream_reader
// PURPOSE
//  Read-side initiator for the pipelined single-port UltraRAM wrapper: accepts a burst command
//  (start address, word count), issues back-to-back reads, absorbs the RAM's fixed read
//  latency and presents the words as a valid/ready stream with a last flag. Sits between the
//  URAM and downstream compute; credit flow control keeps back-pressure from losing read data.
// PARAMETERS
//  AWIDTH     11  URAM address width; bursts wrap modulo 2**AWIDTH
//  DWIDTH     72  URAM data width
//  NBPIPE     3   URAM output pipeline depth; read latency LAT = NBPIPE+2 cycles
//  FIFO_DEPTH 8   output buffer depth, power of two, must be >= LAT+1 (checked at elaboration)
// PORTS
//  clk        in   1          single clock
//  rst_n      in   1          asynchronous, active-low reset
//  cmd_valid  in   1          burst command valid
//  cmd_ready  out  1          high only in IDLE
//  cmd_addr   in   AWIDTH     first word address
//  cmd_len    in   AWIDTH+1   word count, 1..2**AWIDTH; 0 = no-op
//  mem_en     out  1          URAM mem_en; one read per high cycle
//  mem_we     out  1          tied 0
//  mem_regce  out  1          tied 1
//  mem_addr   out  AWIDTH     URAM addr
//  mem_dout   in   DWIDTH     URAM dout
//  m_valid    out  1          stream data valid
//  m_ready    in   1          stream sink ready
//  m_data     out  DWIDTH     stream word
//  m_last     out  1          final word of burst
//  busy       out  1          high from cmd accept until last word handed off
// BEHAVIOUR
//  - Reset: all outputs 0 except cmd_ready=1, mem_regce=1; FSM IDLE, counters/FIFO/flags cleared.
//  - FSM IDLE -> ISSUE on cmd_valid&&cmd_len!=0 (cmd latched, busy=1). cmd_len==0: handshake
//    accepted, stays IDLE, no reads, no stream output.
//  - ISSUE: mem_en=1, mem_addr=cur_addr when credit available, i.e.
//    inflight + fifo_count < FIFO_DEPTH; else mem_en=0 that cycle (stall, addr held).
//    cur_addr increments per issued read, wrapping 2**AWIDTH-1 -> 0. After cmd_len reads -> DRAIN.
//  - DRAIN -> IDLE when inflight==0, FIFO empty and last word accepted (m_valid&&m_ready&&m_last).
//  - Latency tracking: LAT-deep shift register of {valid,last} tags fed by mem_en;
//    tag emerging at cycle t+LAT writes mem_dout into FIFO. inflight = set bits in shift reg
//    (counter, inc on issue, dec on capture; simultaneous -> unchanged).
//  - Credit guarantees FIFO never overflows; write to a full FIFO is an assertion failure.
//  - Stream: m_valid = FIFO non-empty; word pops on m_valid&&m_ready; m_data/m_last stable
//    while m_valid&&!m_ready. Simultaneous push+pop on full or empty FIFO is legal.
//  - Throughput: 1 word/cycle sustained when m_ready held high; first word at m_valid
//    LAT+1 cycles after the cmd handshake edge.
//  - m_last set only on the tag of read index cmd_len-1.
//  - New command not accepted until DRAIN completes (no burst overlap).
//  - Reset mid-burst: async clear of FSM, tags, FIFO; returning URAM data discarded; URAM
//    contents untouched; cmd_ready=1 from first cycle after rst_n deasserts.
// STRUCTURE
//  - Shared header (alongside data_width.vh): FSM state encodings (IDLE/ISSUE/DRAIN),
//    URAM_LAT(NBPIPE) macro = NBPIPE+2.
//  - One sub-module: sync_fifo_fwft (DWIDTH+1 wide, FIFO_DEPTH deep, first-word-fall-through,
//    async active-low reset, full/empty/count outputs).
//  - Top: FSM, address/length counters, tag shift register, inflight counter, credit compare.
// TESTING (bench instantiates uram NBPIPE=3, preloaded mem[i]=i)
//  - Single word: addr=5,len=1,m_ready=1 -> one word 5, m_last=1, m_valid at cycle 6 after cmd.
//  - Burst: addr=0,len=16,m_ready=1 -> 16 consecutive cycles data 0..15, last on 15, no mem_en gaps.
//  - Wrap: addr=2046,len=4 -> data 2046,2047,0,1; mem_addr wraps to 0.
//  - Back-pressure: len=32, m_ready 1-of-3 cycles random -> all 32 in order, no loss,
//    mem_en never issued with inflight+count==8.
//  - len=0: cmd accepted, busy stays 0, no mem_en, no m_valid.
//  - Reset mid-burst: rst_n low at 10th word of len=64 -> outputs reset values; new cmd
//    addr=100,len=2 -> exactly 100,101, no stale words.

Source files
------------

// File: rtl/uram_stream_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uram_stream_reader_pkg                                                   |
// | Shared FSM encodings and URAM read-latency helper for the stream reader. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package uram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Total read latency of the pipelined URAM wrapper: two fixed stages plus NBPIPE.
    function automatic int uram_lat(input int nbpipe);
        return nbpipe + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uram_stream_reader_sync_fifo_fwft.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_fwft                                                           |
// | Single-clock first-word-fall-through FIFO with full/empty/count outputs. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_fifo_fwft #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only honoured when a pop frees the slot in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full && !do_rd));

endmodule
`default_nettype wire

// File: rtl/uram_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uram_stream_reader                                                       |
// | Burst read initiator for a pipelined URAM, credit-flow-controlled stream.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uram_stream_reader
    import uram_stream_reader_pkg::*;
#(
    parameter int AWIDTH     = 11,
    parameter int DWIDTH     = 72,
    parameter int NBPIPE     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_regce,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              busy
);
    localparam int LAT = uram_lat(NBPIPE);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < LAT + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uram_stream_reader: FIFO_DEPTH must be a power of two and >= LAT+1");
    end

    state_e            state_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH:0]   rem_q;
    logic [LAT-1:0]    tag_v_q;
    logic [LAT-1:0]    tag_l_q;
    logic [CW-1:0]     inflight_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DWIDTH:0]   fifo_rd;

    logic              credit;
    logic              issue;
    logic              issue_last;
    logic              capture;
    logic              pop;
    logic              last_pop;

    // Reads still in the URAM pipe already own a FIFO slot, so they count against credit.
    assign credit     = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign issue      = (state_q == ST_ISSUE) && credit;
    assign issue_last = issue && (rem_q == (AWIDTH+1)'(1));
    assign capture    = tag_v_q[LAT-1];
    assign pop        = !fifo_empty && m_ready;
    assign last_pop   = pop && fifo_rd[DWIDTH];

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign mem_en     = issue;
    assign mem_we     = 1'b0;
    assign mem_regce  = 1'b1;
    assign mem_addr   = addr_q;
    assign m_valid    = !fifo_empty;
    assign m_data     = fifo_empty ? '0 : fifo_rd[DWIDTH-1:0];
    assign m_last     = !fifo_empty && fifo_rd[DWIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_len != '0) begin
                        state_q     <= ST_ISSUE;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        addr_q      <= cmd_addr;
                        rem_q       <= cmd_len;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        addr_q <= addr_q + AWIDTH'(1);
                        rem_q  <= rem_q - (AWIDTH+1)'(1);
                        if (issue_last) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop && inflight_q == '0 && fifo_count == CW'(1)) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q    <= '0;
            tag_l_q    <= '0;
            inflight_q <= '0;
        end else begin
            tag_v_q <= {tag_v_q[LAT-2:0], issue};
            tag_l_q <= {tag_l_q[LAT-2:0], issue_last};
            case ({issue, capture})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture),
        .wr_data ({tag_l_q[LAT-1], mem_dout}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    a_no_capture_into_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && fifo_full && !pop));

endmodule
`default_nettype wire

// File: tb/tb_uram_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uram_stream_reader                                                    |
// | Directed + random bursts against a URAM model preloaded with mem[i]=i.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uram_stream_reader;
    localparam int AW    = 11;
    localparam int DW    = 72;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int NWORD = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          mem_en, mem_we, mem_regce;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    uram_stream_reader #(.AWIDTH(AW), .DWIDTH(DW), .NBPIPE(3), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_en(mem_en), .mem_we(mem_we),
        .mem_regce(mem_regce), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // URAM: a read sampled on edge t is presented on dout LAT-1 edges later.
    logic [DW-1:0] mem [NWORD];
    logic [DW-1:0] dq  [LAT];
    always @(posedge clk) begin
        dq[0] <= mem_en ? mem[mem_addr] : '0;
        for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
    end
    assign mem_dout = dq[LAT-1];

    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        m_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [DW:0]   words_q[$];
    int            acc_cyc_q[$];
    int            issue_cyc_q[$];
    logic [AW-1:0] issue_addr_q[$];
    int first_valid = -1;
    int mem_en_cnt = 0, valid_cnt = 0, busy_cnt = 0;
    int issued = 0, popped = 0;
    int hs_cyc = 0;

    // Outstanding words (issued but not yet handed off) must never exceed the buffer.
    always @(negedge clk) begin
        if (!rst_n) begin
            issued = 0;
            popped = 0;
        end else begin
            if (busy) busy_cnt++;
            if (m_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (mem_en) begin
                check("credit", (issued - popped) < DEPTH, 1);
                issue_addr_q.push_back(mem_addr);
                issue_cyc_q.push_back(cyc);
                mem_en_cnt++;
                issued++;
            end
            if (m_valid && m_ready) begin
                words_q.push_back({m_last, m_data});
                acc_cyc_q.push_back(cyc);
                popped++;
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk); #1;
        words_q.delete(); acc_cyc_q.delete(); issue_cyc_q.delete(); issue_addr_q.delete();
        first_valid = -1; mem_en_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    endtask

    task automatic send_cmd(input int addr, input int len);
        int k = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW+1)'(len);
        while (!cmd_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("cmd_ready_wait", k < 200, 1);
        @(posedge clk); #1;
        hs_cyc    = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int len);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(words_q.size() == len && !busy) && k < 3000);
        check("burst_done", (words_q.size() == len) && !busy, 1);
    endtask

    task automatic check_words(input int addr, input int len);
        logic [DW:0] exp;
        check("word_count", words_q.size(), len);
        for (int i = 0; i < len && i < words_q.size(); i++) begin
            exp = {(i == len - 1), DW'((addr + i) % NWORD)};
            check($sformatf("word%0d", i), words_q[i], exp);
        end
    endtask

    task automatic run_burst(input int addr, input int len, input int mode);
        clear_mon();
        rdy_mode = mode;
        send_cmd(addr, len);
        wait_done(len);
        check_words(addr, len);
    endtask

    initial begin
        int a, l, k;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        for (int i = 0; i < NWORD; i++) mem[i] = DW'(i);
        for (int i = 0; i < LAT; i++) dq[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {cmd_ready, mem_en, mem_we, mem_regce, m_valid, m_last, busy}, 7'b1001000);
        check("reset_data", {m_data, mem_addr}, '0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", cmd_ready, 1);

        // Single word: first m_valid LAT+1 cycles after the handshake edge.
        run_burst(5, 1, 0);
        check("single_latency", first_valid - hs_cyc, LAT + 1);

        // Full-rate burst: no issue gaps, one word per cycle.
        run_burst(0, 16, 0);
        check("issue_span", issue_cyc_q[15] - issue_cyc_q[0], 15);
        check("accept_span", acc_cyc_q[15] - acc_cyc_q[0], 15);
        check("issue_count", mem_en_cnt, 16);

        // Address wrap.
        run_burst(2046, 4, 0);
        check("wrap_addr1", issue_addr_q[1], 2047);
        check("wrap_addr2", issue_addr_q[2], 0);

        // Back-pressure with sparse ready.
        run_burst($urandom_range(0, NWORD - 1), 32, 1);

        // Zero-length command.
        clear_mon();
        rdy_mode = 0;
        send_cmd(7, 0);
        repeat (20) @(negedge clk);
        check("len0_busy", busy_cnt, 0);
        check("len0_mem_en", mem_en_cnt, 0);
        check("len0_valid", valid_cnt, 0);
        check("len0_ready", cmd_ready, 1);

        // Random bursts.
        for (int n = 0; n < 4; n++) begin
            a = $urandom_range(0, NWORD - 1);
            l = $urandom_range(1, 40);
            run_burst(a, l, $urandom_range(0, 1));
        end

        // Reset in the middle of a long burst.
        clear_mon();
        rdy_mode = 0;
        send_cmd(0, 64);
        k = 0;
        while (words_q.size() < 10 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("reach_word10", words_q.size() >= 10, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctl", {cmd_ready, mem_en, mem_we, mem_regce, m_valid, m_last, busy}, 7'b1001000);
        check("midrst_data", {m_data, mem_addr}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", {cmd_ready, busy, m_valid}, 3'b100);
        run_burst(100, 2, 0);
        repeat (20) @(negedge clk);
        check("no_stale", words_q.size(), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
